// File: rtl/mem_transfer_sequencer.sv
// Control-word sequencer that moves bytes from the byte-wide memory into the ALU-system datapath.
// A command is either a two-byte IR fetch via PC or a 1..4 byte big-endian DR load via AR, then an RF write.
module mem_transfer_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Cmd,
  input  logic [1:0] Len,
  input  logic [2:0] Dst,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] RF_RegSel,
  output logic [3:0] RF_ScrSel,
  output logic [2:0] RF_FunSel,
  output logic [2:0] RF_OutASel,
  output logic [2:0] RF_OutBSel,
  output logic       ALU_WF,
  output logic [4:0] ALU_FunSel,
  output logic [2:0] ARF_RegSel,
  output logic [1:0] ARF_FunSel,
  output logic [1:0] ARF_OutCSel,
  output logic [1:0] ARF_OutDSel,
  output logic       DR_E,
  output logic [1:0] DR_FunSel,
  output logic       Mem_WR,
  output logic       Mem_CS,
  output logic       IR_LH,
  output logic       IR_Write,
  output logic [1:0] MuxASel,
  output logic [1:0] MuxBSel,
  output logic [1:0] MuxCSel,
  output logic       MuxDSel
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_F_LO   = 3'd1;
  localparam logic [2:0] S_F_HI   = 3'd2;
  localparam logic [2:0] S_L_CLR  = 3'd3;
  localparam logic [2:0] S_L_BYTE = 3'd4;
  localparam logic [2:0] S_L_WB   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0] state;
  logic [1:0] len_q;
  logic [2:0] dst_q;
  logic [1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      len_q <= '0;
      dst_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            len_q <= Len;
            dst_q <= Dst;
            state <= Cmd ? S_L_CLR : S_F_LO;
          end
        end
        S_F_LO:  state <= S_F_HI;
        S_F_HI:  state <= S_DONE;
        S_L_CLR: begin
          cnt   <= len_q;
          state <= S_L_BYTE;
        end
        S_L_BYTE: begin
          // cnt holds the number of bytes still to read after this one
          if (cnt == 2'd0) state <= S_L_WB;
          else             cnt   <= cnt - 2'd1;
        end
        S_L_WB:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets the idle value first, so no path through the case can infer a latch.
  always_comb begin
    Busy        = (state != S_IDLE);
    Done        = 1'b0;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    RF_FunSel   = 3'b000;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    ALU_WF      = 1'b0;
    ALU_FunSel  = 5'b00000;
    ARF_RegSel  = 3'b000;
    ARF_FunSel  = 2'b00;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;

    case (state)
      S_F_LO, S_F_HI: begin
        ARF_OutDSel = 2'b00;
        Mem_CS      = 1'b0;
        IR_Write    = 1'b1;
        IR_LH       = (state == S_F_HI);
        ARF_RegSel  = 3'b100;
        ARF_FunSel  = 2'b01;
      end
      S_L_CLR: begin
        DR_E      = 1'b1;
        DR_FunSel = 2'b00;
      end
      S_L_BYTE: begin
        // byte is shifted into DR at the same edge that advances AR
        ARF_OutDSel = 2'b10;
        Mem_CS      = 1'b0;
        DR_E        = 1'b1;
        DR_FunSel   = 2'b10;
        ARF_RegSel  = 3'b001;
        ARF_FunSel  = 2'b01;
      end
      S_L_WB: begin
        MuxASel   = 2'b10;
        RF_FunSel = 3'b010;
        if (dst_q[2]) RF_ScrSel[dst_q[1:0]] = 1'b1;
        else          RF_RegSel[dst_q[1:0]] = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mem_transfer_sequencer.md
# mem_transfer_sequencer

Control-word generator that moves bytes from the byte-wide memory into the datapath of the ALU system. Each accepted command is either a two-byte instruction fetch into IR via PC, or a 1–4 byte big-endian operand load via AR into DR, which is then written to an RF general or scratch register. It drives every control input of the ALU system and leaves the datapath idle between commands. Handshake is Start/Busy/Done toward the upstream control unit.

## Interface
- No parameters; all encodings are fixed.
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; forces IDLE
- Start  in  1  command request; sampled only in IDLE
- Cmd  in  1  0 = FETCH, 1 = LOAD
- Len  in  2  LOAD byte count minus 1 (N = Len+1, 1..4)
- Dst  in  3  LOAD destination: 0–3 = R1–R4, 4–7 = S1–S4
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse in DONE state
- RF_RegSel, RF_ScrSel  out  4 each  one-hot write enables, bit0 = R1/S1; 0 = hold
- RF_FunSel  out  3  3'b010 = load
- RF_OutASel, RF_OutBSel  out  3 each  constant 0
- ALU_WF  out  1  constant 0; ALU_FunSel out 5, constant 0
- ARF_RegSel  out  3  3'b100 = PC, 3'b001 = AR; 0 = hold
- ARF_FunSel  out  2  2'b01 = increment
- ARF_OutCSel  out  2  constant 0; ARF_OutDSel out 2: 2'b00 = PC, 2'b10 = AR
- DR_E  out  1; DR_FunSel out 2: 2'b00 = clear, 2'b10 = shift left 8 and load byte into [7:0]
- Mem_WR  out  1  constant 0 (read); Mem_CS out 1: 0 = selected
- IR_LH  out  1  0 = low byte, 1 = high byte; IR_Write out 1
- MuxASel  out  2  2'b10 = DR; MuxBSel out 2, MuxCSel out 2, MuxDSel out 1: constant 0

## Operation
- States: IDLE, F_LO, F_HI, L_CLR, L_BYTE, L_WB, DONE. Outputs are a Moore decode of the registered state, byte counter and latched command.
- Idle output word (IDLE, DONE, and reset value of every output): all enables 0, Mem_CS = 1, Busy = 0, Done = 0, every select/function field 0.
- IDLE: on Start, latch Cmd/Len/Dst. Go to F_LO if Cmd = 0, L_CLR if Cmd = 1.
- F_LO: OutDSel = PC, Mem_CS = 0, IR_Write = 1, IR_LH = 0, ARF_RegSel = PC, ARF_FunSel = increment. Go to F_HI.
- F_HI: same as F_LO with IR_LH = 1. Go to DONE. IR[7:0] = M[PC], IR[15:8] = M[PC+1], PC ends at PC+2.
- L_CLR: DR_E = 1, DR_FunSel = clear. Load byte counter = Len. Go to L_BYTE.
- L_BYTE: OutDSel = AR, Mem_CS = 0, DR_E = 1, DR_FunSel = shift-load, ARF_RegSel = AR, ARF_FunSel = increment.
  - If counter = 0, go to L_WB; else decrement the counter and stay.
  - First byte read ends up most significant. Unloaded upper bytes stay zero.
- L_WB: MuxASel = DR, RF_FunSel = load. Dst < 4 sets RF_RegSel bit Dst; Dst ≥ 4 sets RF_ScrSel bit Dst−4. Go to DONE.
- DONE: Done = 1. Go to IDLE.
- Start while Busy is ignored; command inputs are not sampled outside IDLE.
- Only one ARF register is ever enabled per cycle. Memory is never written.

## Timing
- Start sampled at edge 0. FETCH: Done high in cycle 3, so 4 cycles Start-to-idle. LOAD: Done high in cycle N+3.
- Memory read is combinational from Address. Each byte is captured by IR/DR at the same edge that increments PC/AR.
- Reset asserted in any state returns to IDLE at the next edge with the idle output word. No Done is issued. Partial IR/DR/PC/AR updates already clocked are kept.
- Start held continuously: a new command is accepted in the IDLE cycle following DONE.

## Test plan
- Reset, then idle: all outputs match the idle word; Busy = 0, Mem_CS = 1.
- FETCH with PC = 0x0010, M[0x10] = 0x34, M[0x11] = 0x12: Done in cycle 3, IROut = 0x1234, PC = 0x0012.
- LOAD Len = 3, Dst = 1, AR = 0x0020, M = 0xDE, 0xAD, 0xBE, 0xEF: Done in cycle 7, R2 = 0xDEADBEEF, AR = 0x0024, no other register written.
- LOAD Len = 0, Dst = 6, DR preset 0xFFFFFFFF, M[AR] = 0x5A: S3 = 0x0000005A, Done in cycle 4.
- Start pulsed during a LOAD with different Cmd/Dst: ignored; first command completes unchanged, single Done.
- Reset asserted in L_BYTE after 2 of 4 bytes: IDLE next cycle, no RF write, no Done, AR advanced by 2.
